qpsk_symbol_mapper: RTL and testbench

Converts the serial 1-bit payload stream produced by the data packager into QPSK baseband samples for the transmit DAC path. Consecutive bit pairs form one Gray-coded QPSK symbol: the first bit goes to I, the second to Q. Each symbol is held for `SPS` output samples, so the block is a rectangular-pulse upsampler. A one-symbol pending buffer lets the output run gap-free while the upstream keeps pace.

---
 rtl/qpsk_symbol_mapper.sv | 109 ++++++++++
 tb/tb_qpsk_symbol_mapper.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_mapper.sv
// Serial-bit to QPSK rectangular-pulse mapper: pairs bits into Gray-coded symbols (first bit -> I),
// holds each symbol for SPS samples, with a one-symbol pending buffer for gap-free output.
module qpsk_symbol_mapper #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned AMP      = 8192,
  parameter int unsigned SPS      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_i,
  output logic [SAMPLE_W-1:0] out_q,
  output logic                out_sym_start,
  input  logic                out_ready
);

  localparam int unsigned         CntW   = $clog2(SPS);
  localparam logic [CntW-1:0]     CntMax = CntW'(SPS - 1);
  localparam logic [SAMPLE_W-1:0] PosAmp = SAMPLE_W'(AMP);
  localparam logic [SAMPLE_W-1:0] NegAmp = SAMPLE_W'(0) - PosAmp;

  logic            bitcnt_q, bitcnt_d;
  logic            first_bit_q, first_bit_d;
  logic            pend_valid_q, pend_valid_d;
  logic [1:0]      pend_bits_q, pend_bits_d;
  logic            cur_valid_q, cur_valid_d;
  logic [1:0]      cur_bits_q, cur_bits_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic in_fire, out_fire, last_sample, load;

  // in_ready depends on state only, so out_ready never reaches it combinationally
  assign in_ready    = !(pend_valid_q && bitcnt_q);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = cur_valid_q && out_ready;
  assign last_sample = (cnt_q == CntMax);
  assign load        = pend_valid_q && (!cur_valid_q || (out_fire && last_sample));

  always_comb begin
    bitcnt_d     = bitcnt_q;
    first_bit_d  = first_bit_q;
    pend_valid_d = pend_valid_q;
    pend_bits_d  = pend_bits_q;
    cur_valid_d  = cur_valid_q;
    cur_bits_d   = cur_bits_q;
    cnt_d        = cnt_q;

    if (in_fire) begin
      if (!bitcnt_q) begin
        first_bit_d = in_data;
        bitcnt_d    = 1'b1;
      end else begin
        // second bit is only accepted with the pending slot empty, so this never races load
        pend_bits_d  = {first_bit_q, in_data};
        pend_valid_d = 1'b1;
        bitcnt_d     = 1'b0;
      end
    end

    if (load) begin
      cur_valid_d  = 1'b1;
      cur_bits_d   = pend_bits_q;
      cnt_d        = '0;
      pend_valid_d = 1'b0;
    end else if (out_fire) begin
      if (!last_sample) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        cur_valid_d = 1'b0;
        cnt_d       = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q     <= 1'b0;
      first_bit_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_bits_q  <= 2'b00;
      cur_valid_q  <= 1'b0;
      cur_bits_q   <= 2'b00;
      cnt_q        <= '0;
    end else begin
      bitcnt_q     <= bitcnt_d;
      first_bit_q  <= first_bit_d;
      pend_valid_q <= pend_valid_d;
      pend_bits_q  <= pend_bits_d;
      cur_valid_q  <= cur_valid_d;
      cur_bits_q   <= cur_bits_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    out_valid     = cur_valid_q;
    out_sym_start = cur_valid_q && (cnt_q == '0);
    out_i         = '0;
    out_q         = '0;
    if (cur_valid_q) begin
      out_i = cur_bits_q[1] ? NegAmp : PosAmp;
      out_q = cur_bits_q[0] ? NegAmp : PosAmp;
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Scoreboard bench for qpsk_symbol_mapper: dut0 (SPS=4) takes directed tests, dut1 (SPS=2) a
// randomized stress run; a single monitor pops expected samples on every output handshake.
module tb_qpsk_symbol_mapper;

  localparam logic [15:0] Pos = 16'd8192;
  localparam logic [15:0] Neg = 16'hE000;

  logic        clk = 1'b0;
  logic        rst[2];
  logic        in_valid[2];
  logic        in_data[2];
  logic        in_ready[2];
  logic        out_valid[2];
  logic [15:0] out_i[2];
  logic [15:0] out_q[2];
  logic        out_sym_start[2];
  logic        out_ready[2];

  always #5 clk = ~clk;

  qpsk_symbol_mapper #(.SAMPLE_W(16), .AMP(8192), .SPS(4)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_i(out_i[0]), .out_q(out_q[0]),
    .out_sym_start(out_sym_start[0]), .out_ready(out_ready[0])
  );

  qpsk_symbol_mapper #(.SAMPLE_W(16), .AMP(8192), .SPS(2)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_i(out_i[1]), .out_q(out_q[1]),
    .out_sym_start(out_sym_start[1]), .out_ready(out_ready[1])
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: bit pairs -> SPS copies of {I, Q, first-sample flag}
  logic [32:0] exp_mem[2][4096];
  int unsigned wr[2];
  int unsigned rd[2];
  logic        have_first[2];
  logic        first_bit[2];
  int          sps_of[2];

  logic [32:0] prev[2];
  logic        prev_stall[2];
  logic        stress_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_bit(input int g, input logic b);
    if (!have_first[g]) begin
      first_bit[g]  = b;
      have_first[g] = 1'b1;
    end else begin
      for (int k = 0; k < sps_of[g]; k++) begin
        exp_mem[g][wr[g] % 4096] = {(first_bit[g] ? Neg : Pos), (b ? Neg : Pos), (k == 0)};
        wr[g]++;
      end
      have_first[g] = 1'b0;
    end
  endfunction

  // Monitor: stability under backpressure, zeroed idle outputs, scoreboard on handshake
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        rd[g]         = wr[g];
        prev_stall[g] = 1'b0;
      end else begin
        if (prev_stall[g]) begin
          check("hold_valid", 64'(out_valid[g]), 64'd1);
          check("hold_sample", 64'({out_i[g], out_q[g], out_sym_start[g]}), 64'(prev[g]));
        end
        if (!out_valid[g]) begin
          check("idle_zero", 64'({out_i[g], out_q[g], out_sym_start[g]}), 64'd0);
        end else if (out_ready[g]) begin
          vectors++;
          if (rd[g] == wr[g]) begin
            miscompares++;
            $display("FAIL unexpected_sample dut%0d: got %0h, required none", g,
                     {out_i[g], out_q[g], out_sym_start[g]});
          end else begin
            if ({out_i[g], out_q[g], out_sym_start[g]} !== exp_mem[g][rd[g] % 4096]) begin
              miscompares++;
              $display("FAIL sample dut%0d: got %0h, required %0h", g,
                       {out_i[g], out_q[g], out_sym_start[g]}, exp_mem[g][rd[g] % 4096]);
            end
            rd[g]++;
          end
        end
        prev_stall[g] = out_valid[g] && !out_ready[g];
        prev[g]       = {out_i[g], out_q[g], out_sym_start[g]};
      end
    end
  end

  // Retries until accepted, then drops in_valid after the accepting edge
  task automatic send_bit(input int g, input logic b);
    int   n = 0;
    logic acc = 1'b0;
    while (!acc) begin
      @(posedge clk); #1;
      in_valid[g] = 1'b1;
      in_data[g]  = b;
      @(negedge clk);
      acc = in_ready[g];
      if (acc) model_bit(g, b);
      else if (++n > 200) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic do_reset(input int g);
    @(posedge clk); #1;
    rst[g]        = 1'b1;
    in_valid[g]   = 1'b0;
    have_first[g] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g);
    int n = 0;
    @(negedge clk);
    while (!out_valid[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", 64'(out_valid[g]), 64'd1);
  endtask

  task automatic wait_drain(input int g);
    int n = 0;
    @(negedge clk);
    while ((rd[g] != wr[g] || out_valid[g]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(wr[g] - rd[g]), 64'd0);
    check("drain_valid", 64'(out_valid[g]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    sps_of[0] = 4;
    sps_of[1] = 2;
    stress_done = 1'b0;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; in_valid[g] = 1'b0; in_data[g] = 1'b0; out_ready[g] = 1'b1;
      wr[g] = 0; rd[g] = 0; have_first[g] = 1'b0; first_bit[g] = 1'b0;
      prev_stall[g] = 1'b0; prev[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;

    // Reset values
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_in_ready", 64'(in_ready[g]), 64'd1);
      check("rst_out_valid", 64'(out_valid[g]), 64'd0);
      check("rst_out_iq", 64'({out_i[g], out_q[g]}), 64'd0);
    end

    // One symbol (0,1) with latency check
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    @(negedge clk);
    check("lat_k", 64'(out_valid[0]), 64'd0);
    @(negedge clk);
    check("lat_k1", 64'(out_valid[0]), 64'd1);
    check("first_i", 64'(out_i[0]), 64'(Pos));
    check("first_q", 64'(out_q[0]), 64'(Neg));
    check("first_start", 64'(out_sym_start[0]), 64'd1);
    wait_drain(0);

    // Back-to-back 00 01 10 11: 16 contiguous samples then a gap
    fork
      begin
        logic [7:0] pat;
        pat = 8'b00_01_10_11;
        for (int k = 7; k >= 0; k--) send_bit(0, pat[k]);
      end
      begin
        wait_valid(0);
        for (int k = 0; k < 16; k++) begin
          check("contig_valid", 64'(out_valid[0]), 64'd1);
          check("contig_start", 64'(out_sym_start[0]), 64'(k % 4 == 0));
          @(negedge clk);
        end
        check("contig_end", 64'(out_valid[0]), 64'd0);
      end
    join
    wait_drain(0);

    // Backpressure mid-symbol: pend fills, one more bit, then in_ready drops
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    wait_valid(0);
    @(negedge clk);
    @(posedge clk); #1 out_ready[0] = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid[0] = 1'b1;
      in_data[0]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready[0]) begin
        model_bit(0, in_data[0]);
        acc++;
      end
    end
    @(posedge clk); #1 in_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready", 64'(in_ready[0]), 64'd0);
    check("bp_out_valid", 64'(out_valid[0]), 64'd1);
    @(posedge clk); #1 out_ready[0] = 1'b1;

    // Reset with a partial pair held and a symbol active
    repeat (3) @(negedge clk);
    check("pre_rst_active", 64'(out_valid[0]), 64'd1);
    do_reset(0);
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid[0]), 64'd0);
    check("post_rst_ready", 64'(in_ready[0]), 64'd1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    wait_valid(0);
    check("rst_pair_i", 64'(out_i[0]), 64'(Neg));
    check("rst_pair_q", 64'(out_q[0]), 64'(Neg));
    wait_drain(0);

    // SPS=2 random stress, 10k accepted bits
    fork
      begin
        while (!stress_done) begin
          @(posedge clk); #1 out_ready[1] = 1'($urandom_range(0, 1));
        end
      end
      begin
        int cyc = 0;
        acc = 0;
        while (acc < 10000 && cyc < 80000) begin
          @(posedge clk); #1;
          in_valid[1] = 1'($urandom_range(0, 1));
          in_data[1]  = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (in_valid[1] && in_ready[1]) begin
            model_bit(1, in_data[1]);
            acc++;
          end
          cyc++;
        end
        @(posedge clk); #1 in_valid[1] = 1'b0;
        stress_done = 1'b1;
      end
    join
    check("stress_bits", 64'(acc), 64'd10000);
    @(posedge clk); #1 out_ready[1] = 1'b1;
    wait_drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
